// File: rtl/zii_pkg.sv
// Shared definitions for the Zorro II fast-RAM arbiter.
//  - state_t       : arbiter FSM states
//  - CHUNKS_4MB/8MB: window size in 2 MB chunks (A[23:21] units)
//  - GNT_CPU/ZII   : grant encoding, also used as the RAM_SEL value
//  - window_chunks : chunk count for the JP4 window-size jumper
package zii_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    ACCESS  = 3'd2,
    DONE    = 3'd3,
    RECOVER = 3'd4
  } state_t;

  localparam logic [3:0] CHUNKS_4MB = 4'd2;
  localparam logic [3:0] CHUNKS_8MB = 4'd4;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_ZII = 1'b1;

  // JP4 fitted selects the 8 MB window; otherwise 4 MB.
  function automatic logic [3:0] window_chunks(input logic jp4);
    return jp4 ? CHUNKS_8MB : CHUNKS_4MB;
  endfunction

endpackage

// File: rtl/zii_ram_arbiter_if.sv
// Bus bundle between the requesters/autoconfig logic and the RAM arbiter.
//  Config  : RAM_CONFIGURED_n, JP4, BASE_RAM[2:0]
//  CPU     : CPU_REQ, CPU_ADDR[22:0] (A[23:1]), CPU_RW_n, CPU_ACK
//  Zorro II: ZII_REQ, ZII_ADDR[22:0] (A[23:1]), ZII_RW_n, ZII_DTACK_n
//  SRAM    : RAM_SEL, RAM_CE_n, RAM_OE_n, RAM_WE_n, RAM_BUSY
// slave modport is the arbiter; master modport is the requester side.
interface zii_ram_arbiter_if;

  logic        RAM_CONFIGURED_n;
  logic        JP4;
  logic [2:0]  BASE_RAM;

  logic        CPU_REQ;
  logic [22:0] CPU_ADDR;
  logic        CPU_RW_n;
  logic        CPU_ACK;

  logic        ZII_REQ;
  logic [22:0] ZII_ADDR;
  logic        ZII_RW_n;
  logic        ZII_DTACK_n;

  logic        RAM_SEL;
  logic        RAM_CE_n;
  logic        RAM_OE_n;
  logic        RAM_WE_n;
  logic        RAM_BUSY;

  modport slave (
    input  RAM_CONFIGURED_n, JP4, BASE_RAM,
    input  CPU_REQ, CPU_ADDR, CPU_RW_n,
    output CPU_ACK,
    input  ZII_REQ, ZII_ADDR, ZII_RW_n,
    output ZII_DTACK_n,
    output RAM_SEL, RAM_CE_n, RAM_OE_n, RAM_WE_n, RAM_BUSY
  );

  modport master (
    output RAM_CONFIGURED_n, JP4, BASE_RAM,
    output CPU_REQ, CPU_ADDR, CPU_RW_n,
    input  CPU_ACK,
    output ZII_REQ, ZII_ADDR, ZII_RW_n,
    input  ZII_DTACK_n,
    input  RAM_SEL, RAM_CE_n, RAM_OE_n, RAM_WE_n, RAM_BUSY
  );

endinterface

// File: rtl/zii_ram_window_decode.sv
// Decodes one requester's A[23:21] against the autoconfigured RAM window.
//  base_ram         in  3  window base, A[23:21]
//  jp4              in  1  1: 4 chunks (8 MB), 0: 2 chunks (4 MB)
//  ram_configured_n in  1  low once the base has been assigned
//  addr_hi          in  3  requester A[23:21]
//  hit              out 1  address falls inside the window
module zii_ram_window_decode
  import zii_pkg::*;
(
  input  logic [2:0] base_ram,
  input  logic       jp4,
  input  logic       ram_configured_n,
  input  logic [2:0] addr_hi,
  output logic       hit
);

  logic [3:0] window_end;

  // Upper bound computed in 4 bits so a window near the top of the
  // 16 MB space cannot wrap around to chunk 0.
  assign window_end = {1'b0, base_ram} + window_chunks(jp4);

  assign hit = !ram_configured_n
             && (addr_hi >= base_ram)
             && ({1'b0, addr_hi} < window_end);

endmodule

// File: rtl/zii_ram_arbiter.sv
// Zorro II fast-RAM arbiter: shares the SRAM between the local CPU and
// Zorro II bus masters, sequencing CE/OE/WE with programmable wait states.
//  C7M    in  1  clock (posedge)
//  RESET  in  1  synchronous, active-high reset
//  bus    slave modport of zii_ram_arbiter_if (requests, acks, SRAM strobes)
// Parameters:
//  WAIT_STATES  cycles spent in ACCESS (1..7)
//  ZII_PRIORITY 1: Zorro II wins every tie; 0: round-robin on ties
module zii_ram_arbiter
  import zii_pkg::*;
#(
  parameter int WAIT_STATES  = 1,
  parameter bit ZII_PRIORITY = 1'b0
)
(
  input  logic            C7M,
  input  logic            RESET,
  zii_ram_arbiter_if.slave bus
);

  localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES);

  // Requester vectors indexed by grant encoding (GNT_CPU = 0, GNT_ZII = 1).
  logic [2:0] addr_hi [2];
  logic [1:0] win_hit;
  logic [1:0] req_raw;
  logic [1:0] rw_raw;
  logic [1:0] req_hit;

  assign addr_hi[0] = bus.CPU_ADDR[22:20];
  assign addr_hi[1] = bus.ZII_ADDR[22:20];
  assign req_raw    = {bus.ZII_REQ,  bus.CPU_REQ};
  assign rw_raw     = {bus.ZII_RW_n, bus.CPU_RW_n};

  // Only A[23:21] take part in the window decode.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.CPU_ADDR[19:0], bus.ZII_ADDR[19:0]};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_decode
      zii_ram_window_decode u_decode (
        .base_ram         (bus.BASE_RAM),
        .jp4              (bus.JP4),
        .ram_configured_n (bus.RAM_CONFIGURED_n),
        .addr_hi          (addr_hi[gi]),
        .hit              (win_hit[gi])
      );
      assign req_hit[gi] = req_raw[gi] && win_hit[gi];
    end
  endgenerate

  state_t     state_reg;
  logic [2:0] wait_cnt_reg;
  logic       grant_reg;
  logic       last_grant_reg;
  logic       rw_reg;
  logic       abort_reg;
  logic       sel_reg;
  logic       ce_n_reg;
  logic       oe_n_reg;
  logic       we_n_reg;
  logic       cpu_ack_reg;
  logic       zii_dtack_n_reg;

  logic       grant_valid;
  logic       grant_next;

  // Tie-break: fixed Zorro II priority, or whoever did not win last time.
  always_comb begin
    grant_valid = |req_hit;
    grant_next  = GNT_CPU;
    if (req_hit[GNT_ZII] && req_hit[GNT_CPU]) begin
      grant_next = ZII_PRIORITY ? GNT_ZII : ~last_grant_reg;
    end else if (req_hit[GNT_ZII]) begin
      grant_next = GNT_ZII;
    end
  end

  always_ff @(posedge C7M) begin
    if (RESET) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      grant_reg       <= GNT_CPU;
      last_grant_reg  <= GNT_CPU;
      rw_reg          <= 1'b1;
      abort_reg       <= 1'b0;
      sel_reg         <= 1'b0;
      ce_n_reg        <= 1'b1;
      oe_n_reg        <= 1'b1;
      we_n_reg        <= 1'b1;
      cpu_ack_reg     <= 1'b0;
      zii_dtack_n_reg <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          ce_n_reg        <= 1'b1;
          oe_n_reg        <= 1'b1;
          we_n_reg        <= 1'b1;
          cpu_ack_reg     <= 1'b0;
          zii_dtack_n_reg <= 1'b1;
          if (grant_valid) begin
            grant_reg <= grant_next;
            rw_reg    <= rw_raw[grant_next];
            sel_reg   <= grant_next;
            abort_reg <= 1'b0;
            state_reg <= SETUP;
          end
        end

        SETUP: begin
          ce_n_reg     <= 1'b0;
          wait_cnt_reg <= WAIT_INIT;
          if (!req_raw[grant_reg]) abort_reg <= 1'b1;
          state_reg    <= ACCESS;
        end

        // The access always runs its full count, even when the requester
        // has gone away, so a started write is never truncated.
        ACCESS: begin
          ce_n_reg <= 1'b0;
          oe_n_reg <= ~rw_reg;
          we_n_reg <= rw_reg;
          if (!req_raw[grant_reg]) abort_reg <= 1'b1;
          if (wait_cnt_reg <= 3'd1) begin
            state_reg <= DONE;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 3'd1;
          end
        end

        // WE rises on entry while CE stays low, holding write data one
        // more cycle. The ack is held until the requester lets go.
        DONE: begin
          we_n_reg <= 1'b1;
          if (abort_reg || !req_raw[grant_reg]) begin
            ce_n_reg        <= 1'b1;
            oe_n_reg        <= 1'b1;
            cpu_ack_reg     <= 1'b0;
            zii_dtack_n_reg <= 1'b1;
            state_reg       <= RECOVER;
          end else begin
            ce_n_reg        <= 1'b0;
            oe_n_reg        <= ~rw_reg;
            cpu_ack_reg     <= (grant_reg == GNT_CPU);
            zii_dtack_n_reg <= (grant_reg != GNT_ZII);
          end
        end

        RECOVER: begin
          ce_n_reg        <= 1'b1;
          oe_n_reg        <= 1'b1;
          we_n_reg        <= 1'b1;
          cpu_ack_reg     <= 1'b0;
          zii_dtack_n_reg <= 1'b1;
          last_grant_reg  <= grant_reg;
          state_reg       <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // RAM_SEL keeps the last grant while idle; the muxes are don't-care then.
  assign bus.RAM_SEL     = sel_reg;
  assign bus.RAM_CE_n    = ce_n_reg;
  assign bus.RAM_OE_n    = oe_n_reg;
  assign bus.RAM_WE_n    = we_n_reg;
  assign bus.CPU_ACK     = cpu_ack_reg;
  assign bus.ZII_DTACK_n = zii_dtack_n_reg;
  assign bus.RAM_BUSY    = (state_reg != IDLE);

endmodule

// File: tb/tb_zii_ram_arbiter.sv
// Directed bench for zii_ram_arbiter (WAIT_STATES = 1, round-robin ties).
// Output vector order: {CE_n, OE_n, WE_n, CPU_ACK, ZII_DTACK_n, RAM_SEL, RAM_BUSY}
module tb_zii_ram_arbiter;

  logic C7M = 1'b0;
  logic RESET;

  always #5 C7M = ~C7M;

  zii_ram_arbiter_if bus_if ();

  zii_ram_arbiter #(
    .WAIT_STATES  (1),
    .ZII_PRIORITY (1'b0)
  ) dut (
    .C7M   (C7M),
    .RESET (RESET),
    .bus   (bus_if)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] V_IDLE = 7'b1110100;
  // Tie winners for the four round-robin rounds: bit r = 1 means Zorro II.
  localparam logic [3:0] RR_EXP = 4'b0101;

  function automatic logic [6:0] outs();
    return {bus_if.RAM_CE_n, bus_if.RAM_OE_n, bus_if.RAM_WE_n, bus_if.CPU_ACK,
            bus_if.ZII_DTACK_n, bus_if.RAM_SEL, bus_if.RAM_BUSY};
  endfunction

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Vector check that ignores RAM_SEL (latched value while idle).
  task automatic chk_nosel(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = outs();
    chk(tag, {got[6:2], got[0]}, {exp[6:2], exp[0]});
  endtask

  initial begin
    RESET = 1'b1;
    bus_if.RAM_CONFIGURED_n = 1'b0;
    bus_if.JP4      = 1'b1;
    bus_if.BASE_RAM = 3'b001;
    bus_if.CPU_REQ  = 1'b0;
    bus_if.CPU_ADDR = '0;
    bus_if.CPU_RW_n = 1'b1;
    bus_if.ZII_REQ  = 1'b0;
    bus_if.ZII_ADDR = '0;
    bus_if.ZII_RW_n = 1'b1;
    tick();
    tick();
    chk("reset_outs", outs(), V_IDLE);
    RESET = 1'b0;
    tick();
    chk("post_reset_idle", outs(), V_IDLE);

    // 1: CPU read at $200000
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_ADDR = 23'h100000;
    bus_if.CPU_RW_n = 1'b1;
    tick(); chk("t1_e0_setup",  outs(), 7'b1110101);
    tick(); chk("t1_e1_ce",     outs(), 7'b0110101);
    tick(); chk("t1_e2_oe",     outs(), 7'b0010101);
    tick(); chk("t1_e3_ack",    outs(), 7'b0011101);
    tick(); chk("t1_e4_hold",   outs(), 7'b0011101);
    bus_if.CPU_REQ = 1'b0;
    tick(); chk("t1_recover",   outs(), 7'b1110101);
    tick(); chk("t1_idle",      outs(), V_IDLE);
    $display("txn 1: cpu read $200000 done");

    // 2: Zorro II write at $9FFFFE (hit) then $A00000 (miss)
    bus_if.ZII_REQ  = 1'b1;
    bus_if.ZII_ADDR = 23'h4FFFFF;
    bus_if.ZII_RW_n = 1'b0;
    tick(); chk("t2_e0_setup",  outs(), 7'b1110111);
    tick(); chk("t2_e1_ce",     outs(), 7'b0110111);
    tick(); chk("t2_e2_we",     outs(), 7'b0100111);
    tick(); chk("t2_e3_dtack",  outs(), 7'b0110011);
    bus_if.ZII_REQ = 1'b0;
    tick(); chk("t2_recover",   outs(), 7'b1110111);
    tick(); chk_nosel("t2_idle", V_IDLE);
    $display("txn 2a: zii write $9FFFFE done");
    bus_if.ZII_REQ  = 1'b1;
    bus_if.ZII_ADDR = 23'h500000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_nosel($sformatf("t2_miss_%0d", i), V_IDLE);
    end
    bus_if.ZII_REQ = 1'b0;
    $display("txn 2b: zii write $A00000 ignored");

    // 3: simultaneous hits, round-robin from reset (last_grant = CPU)
    RESET = 1'b1;
    tick();
    chk("t3_reset", outs(), V_IDLE);
    RESET = 1'b0;
    bus_if.CPU_ADDR = 23'h100000;
    bus_if.CPU_RW_n = 1'b1;
    bus_if.ZII_ADDR = 23'h200000;
    bus_if.ZII_RW_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      bus_if.CPU_REQ = 1'b1;
      bus_if.ZII_REQ = 1'b1;
      tick(); tick(); tick(); tick();
      chk($sformatf("t3_round%0d_winner", r),
          {bus_if.CPU_ACK, bus_if.ZII_DTACK_n, bus_if.RAM_SEL},
          RR_EXP[r] ? 3'b001 : 3'b110);
      bus_if.CPU_REQ = 1'b0;
      bus_if.ZII_REQ = 1'b0;
      tick(); tick();
      chk($sformatf("t3_round%0d_idle", r), bus_if.RAM_BUSY, 1'b0);
      $display("txn 3.%0d: tie granted %s", r, bus_if.RAM_SEL ? "zii" : "cpu");
    end

    // 4: Zorro II write aborted in ACCESS, pending CPU read then served
    bus_if.ZII_REQ  = 1'b1;
    bus_if.ZII_ADDR = 23'h4FFFFF;
    bus_if.ZII_RW_n = 1'b0;
    tick(); chk("t4_e0_zii",     outs(), 7'b1110111);
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_ADDR = 23'h180000;
    bus_if.CPU_RW_n = 1'b1;
    tick(); chk("t4_e1_ce",      outs(), 7'b0110111);
    bus_if.ZII_REQ = 1'b0;
    tick(); chk("t4_e2_we",      outs(), 7'b0100111);
    tick(); chk("t4_e3_nodtack", outs(), 7'b1110111);
    tick(); chk("t4_e4_idle",    outs(), 7'b1110110);
    tick(); chk("t4_cpu_grant",  outs(), 7'b1110101);
    tick(); chk("t4_cpu_ce",     outs(), 7'b0110101);
    tick(); chk("t4_cpu_oe",     outs(), 7'b0010101);
    tick(); chk("t4_cpu_ack",    outs(), 7'b0011101);
    bus_if.CPU_REQ = 1'b0;
    tick(); tick();
    chk("t4_idle", outs(), V_IDLE);
    $display("txn 4: aborted zii write, pending cpu served");

    // 5: reset asserted in DONE while CPU_ACK is high
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_ADDR = 23'h100000;
    tick(); tick(); tick(); tick();
    chk("t5_ack_before", bus_if.CPU_ACK, 1'b1);
    RESET = 1'b1;
    tick();
    chk("t5_reset_outs", outs(), V_IDLE);
    bus_if.CPU_REQ = 1'b0;
    RESET = 1'b0;
    tick();
    chk("t5_idle", outs(), V_IDLE);
    $display("txn 5: reset during ack");

    // 6: window at the top of the address space, then unconfigured
    bus_if.BASE_RAM = 3'b111;
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_ADDR = 23'h700000;
    tick(); tick(); tick(); tick();
    chk("t6_top_hit_ack", bus_if.CPU_ACK, 1'b1);
    bus_if.CPU_REQ = 1'b0;
    tick(); tick();
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_ADDR = 23'h000000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t6_nowrap_%0d", i), outs(), V_IDLE);
    end
    bus_if.CPU_REQ = 1'b0;
    tick();
    bus_if.BASE_RAM = 3'b001;
    bus_if.RAM_CONFIGURED_n = 1'b1;
    bus_if.CPU_REQ  = 1'b1;
    bus_if.CPU_ADDR = 23'h100000;
    bus_if.ZII_REQ  = 1'b1;
    bus_if.ZII_ADDR = 23'h100000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("t6_unconfig_%0d", i), outs(), V_IDLE);
    end
    bus_if.CPU_REQ = 1'b0;
    bus_if.ZII_REQ = 1'b0;
    $display("txn 6: top window no wrap, unconfigured ignored");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
